// File: rtl/div_16_if.sv
// Request/result bundle for the 16-bit divider: operands and start go in,
// registered results, status flags and the done/busy handshake come out.
interface div_16_if;
    logic        start;
    logic        op_sel;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] quo;
    logic [15:0] rem;
    logic        busy;
    logic        done;
    logic        dz;
    logic        v;
    logic        n;
    logic        z;

    modport master (
        output start, op_sel, A, B,
        input  quo, rem, busy, done, dz, v, n, z
    );

    modport slave (
        input  start, op_sel, A, B,
        output quo, rem, busy, done, dz, v, n, z
    );
endinterface

// File: rtl/div_16.sv
// 16-bit restoring divider, unsigned or signed (truncating toward zero),
// one quotient bit per cycle; divide-by-zero short-circuits straight to DONE.
module div_16 (
    input  logic     clk,
    input  logic     rst,
    div_16_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        ovf_q, ovf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] pr_q, pr_d;
    logic [15:0] dvd_q, dvd_d;
    logic [15:0] dvs_q, dvs_d;
    logic [15:0] quo_q, quo_d;
    logic [15:0] rem_q, rem_d;
    logic        dz_q, dz_d;
    logic        v_q, v_d;

    logic [17:0] trial;
    logic [15:0] a_mag;
    logic [15:0] b_mag;

    // Shift the next dividend bit into the partial remainder and try subtracting.
    assign trial = {pr_q, dvd_q[15]} - {2'b00, dvs_q};
    assign a_mag = (bus.op_sel && bus.A[15]) ? (16'd0 - bus.A) : bus.A;
    assign b_mag = (bus.op_sel && bus.B[15]) ? (16'd0 - bus.B) : bus.B;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        v_d     = v_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    op_d   = bus.op_sel;
                    qneg_d = bus.A[15] ^ bus.B[15];
                    rneg_d = bus.A[15];
                    ovf_d  = bus.op_sel && (bus.A == 16'h8000) && (bus.B == 16'hFFFF);
                    dvd_d  = a_mag;
                    dvs_d  = b_mag;
                    pr_d   = 17'd0;
                    cnt_d  = 4'd0;
                    if (bus.B == 16'd0) begin
                        quo_d   = 16'hFFFF;
                        rem_d   = bus.A;
                        dz_d    = 1'b1;
                        v_d     = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                pr_d  = trial[17] ? {pr_q[15:0], dvd_q[15]} : trial[16:0];
                dvd_d = {dvd_q[14:0], ~trial[17]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Overflow case needs no special result: |0x8000|/1 negated twice is 0x8000.
                quo_d   = (op_q && qneg_q) ? (16'd0 - dvd_q) : dvd_q;
                rem_d   = (op_q && rneg_q) ? (16'd0 - pr_q[15:0]) : pr_q[15:0];
                dz_d    = 1'b0;
                v_d     = ovf_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= 4'd0;
            pr_q    <= 17'd0;
            dvd_q   <= 16'd0;
            dvs_q   <= 16'd0;
            quo_q   <= 16'd0;
            rem_q   <= 16'd0;
            dz_q    <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            v_q     <= v_d;
        end
    end

    assign bus.quo  = quo_q;
    assign bus.rem  = rem_q;
    assign bus.dz   = dz_q;
    assign bus.v    = v_q;
    assign bus.n    = quo_q[15];
    assign bus.z    = (quo_q == 16'd0);
    assign bus.busy = (state_q == CALC) || (state_q == FIX);
    assign bus.done = (state_q == DONE);
endmodule
